// File: rtl/battery_hud_ctrl.sv
// Battery HUD sprite controller: frame-synchronous energy level, sprite selection,
// empty-state blink and sprite-ROM addressing aligned with the ROM's one-cycle latency.
module battery_hud_ctrl #(
    parameter int SPR_W        = 62,
    parameter int SPR_H        = 22,
    parameter int POS_X        = 560,
    parameter int POS_Y        = 8,
    parameter int LEVEL_MAX    = 15,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        energy_dec,
    input  logic        energy_refill,
    output logic [10:0] rom_address,
    output logic [1:0]  rom_sel,
    output logic        sprite_on,
    output logic [3:0]  energy,
    output logic        empty
);

    localparam logic [9:0]  X_LO  = 10'(POS_X);
    localparam logic [9:0]  X_HI  = 10'(POS_X + SPR_W - 1);
    localparam logic [9:0]  Y_LO  = 10'(POS_Y);
    localparam logic [9:0]  Y_HI  = 10'(POS_Y + SPR_H - 1);
    localparam logic [10:0] W11   = 11'(SPR_W);
    localparam logic [3:0]  LMAX  = 4'(LEVEL_MAX);
    localparam int          BW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ACTIVE,
        EMPTY_SHOW,
        EMPTY_HIDE
    } state_t;

    state_t        state, state_next;
    logic [BW-1:0] blink_cnt, blink_next;
    logic [3:0]    pending_dec;
    logic          pending_ref;
    logic          origin_q;
    logic          at_origin;
    logic          frame_tick;
    logic          in_win;
    logic [10:0]   dx, dy;
    logic [3:0]    energy_applied;
    logic [1:0]    level_sel;

    assign in_win = (DrawX >= X_LO) && (DrawX <= X_HI) &&
                    (DrawY >= Y_LO) && (DrawY <= Y_HI);

    always_comb begin
        dx          = {1'b0, DrawX - X_LO};
        dy          = {1'b0, DrawY - Y_LO};
        rom_address = '0;
        if (in_win)
            rom_address = dx + dy * W11;
    end

    // origin_q resets high so a reset released at (0,0) does not fire a tick
    assign at_origin  = (DrawX == '0) && (DrawY == '0);
    assign frame_tick = at_origin && !origin_q;

    always_comb begin
        energy_applied = '0;
        if (pending_ref)
            energy_applied = LMAX;
        else if (energy > pending_dec)
            energy_applied = energy - pending_dec;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            origin_q    <= 1'b1;
            pending_dec <= '0;
            pending_ref <= 1'b0;
            energy      <= LMAX;
        end else begin
            origin_q <= at_origin;
            if (frame_tick) begin
                // events coinciding with the tick belong to the next frame
                pending_dec <= energy_dec ? 4'd1 : 4'd0;
                pending_ref <= energy_refill;
                energy      <= energy_applied;
            end else begin
                if (energy_dec && pending_dec != LMAX)
                    pending_dec <= pending_dec + 4'd1;
                if (energy_refill)
                    pending_ref <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        blink_next = blink_cnt;
        if (frame_tick) begin
            case (state)
                ACTIVE: begin
                    blink_next = '0;
                    if (energy_applied == '0)
                        state_next = EMPTY_SHOW;
                end
                EMPTY_SHOW, EMPTY_HIDE: begin
                    if (energy_applied != '0) begin
                        state_next = ACTIVE;
                        blink_next = '0;
                    end else if (blink_cnt == BLAST) begin
                        state_next = (state == EMPTY_SHOW) ? EMPTY_HIDE : EMPTY_SHOW;
                        blink_next = '0;
                    end else begin
                        blink_next = blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = ACTIVE;
                    blink_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state     <= ACTIVE;
            blink_cnt <= '0;
        end else begin
            state     <= state_next;
            blink_cnt <= blink_next;
        end
    end

    always_comb begin
        level_sel = 2'd3;
        if (energy >= 4'd10)
            level_sel = 2'd0;
        else if (energy >= 4'd5)
            level_sel = 2'd1;
        else if (energy >= 4'd1)
            level_sel = 2'd2;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sprite_on <= 1'b0;
            rom_sel   <= 2'd0;
        end else begin
            sprite_on <= in_win && blank && (state != EMPTY_HIDE);
            rom_sel   <= level_sel;
        end
    end

    assign empty = (energy == '0);

endmodule
